// File: rtl/dand_bus_arbiter_if.sv
// Requester and downstream bus bundle for dand_bus_arbiter.
// master: the arbiter side; slave: core requesters plus interconnect.
interface dand_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              i_cmd_valid;
  logic              i_cmd_ready;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rsp_data;
  logic              i_rsp_error;

  logic              d_cmd_valid;
  logic              d_cmd_ready;
  logic [ADDR_W-1:0] d_cmd_addr;
  logic              d_cmd_write;
  logic [DATA_W-1:0] d_cmd_wdata;
  logic [STRB_W-1:0] d_cmd_wstrb;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;
  logic              d_rsp_error;

  logic              m_cmd_valid;
  logic              m_cmd_ready;
  logic [ADDR_W-1:0] m_cmd_addr;
  logic              m_cmd_write;
  logic [DATA_W-1:0] m_cmd_wdata;
  logic [STRB_W-1:0] m_cmd_wstrb;
  logic              m_rsp_valid;
  logic [DATA_W-1:0] m_rsp_data;
  logic              m_rsp_error;

  modport master (
    input  i_cmd_valid, i_cmd_addr,
    output i_cmd_ready,
    output i_rsp_valid, i_rsp_data, i_rsp_error,
    input  d_cmd_valid, d_cmd_addr, d_cmd_write,
    input  d_cmd_wdata, d_cmd_wstrb,
    output d_cmd_ready,
    output d_rsp_valid, d_rsp_data, d_rsp_error,
    output m_cmd_valid, m_cmd_addr, m_cmd_write,
    output m_cmd_wdata, m_cmd_wstrb,
    input  m_cmd_ready,
    input  m_rsp_valid, m_rsp_data, m_rsp_error
  );

  modport slave (
    output i_cmd_valid, i_cmd_addr,
    input  i_cmd_ready,
    input  i_rsp_valid, i_rsp_data, i_rsp_error,
    output d_cmd_valid, d_cmd_addr, d_cmd_write,
    output d_cmd_wdata, d_cmd_wstrb,
    input  d_cmd_ready,
    input  d_rsp_valid, d_rsp_data, d_rsp_error,
    input  m_cmd_valid, m_cmd_addr, m_cmd_write,
    input  m_cmd_wdata, m_cmd_wstrb,
    output m_cmd_ready,
    output m_rsp_valid, m_rsp_data, m_rsp_error
  );
endinterface

// File: rtl/dand_bus_arbiter.sv
// ibus/dbus arbiter: one outstanding transaction, response timeout.
// DAND_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module dand_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  io_axiClk,
  input  logic                  io_asyncResetn,
  dand_bus_arbiter_if.master    bus,
  output logic                  o_busy,
  output logic                  o_owner
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TMO_LAST =
    (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RSP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic              any_req;
  logic              pick_d;
  logic              grant_i;
  logic              grant_d;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              done;
  logic              tmo;
  logic              tmo_hit;

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              owner_q;

  logic              i_vld_q;
  logic [DATA_W-1:0] i_data_q;
  logic              i_err_q;
  logic              d_vld_q;
  logic [DATA_W-1:0] d_data_q;
  logic              d_err_q;
  logic [DATA_W-1:0] rsp_data_n;
  logic              rsp_err_n;

  // Reset gates grants so every output reads 0 while held in reset.
  assign any_req = io_asyncResetn &
                   (bus.i_cmd_valid | bus.d_cmd_valid);

`ifdef DAND_ARB_ROUND_ROBIN_EN
  logic last_d_q;

  // A tie goes to whoever lost the previous tie.
  assign pick_d = bus.d_cmd_valid &
                  (~bus.i_cmd_valid | ~last_d_q);

  // Remember the winner of each tie; first tie goes to ibus.
  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      last_d_q <= 1'b1;
    end else if (grant_i && bus.d_cmd_valid) begin
      last_d_q <= 1'b0;
    end else if (grant_d && bus.i_cmd_valid) begin
      last_d_q <= 1'b1;
    end
  end
`else
  assign pick_d = bus.d_cmd_valid;
`endif

  assign tmo_hit = (TIMEOUT_CYC != 0) &&
                   (cnt_q == CW'(TMO_LAST));

  // State register.
  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, grants and response events.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = CMD;
          grant_d = pick_d;
          grant_i = ~pick_d;
        end
      end
      CMD: begin
        if (bus.m_cmd_ready) begin
          state_d = RSP;
          cnt_clr = 1'b1;
        end
      end
      RSP: begin
        if (bus.m_rsp_valid) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Cycles spent waiting for the response.
  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Capture the winning command; ibus carries no write fields.
  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      owner_q <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= bus.d_cmd_addr;
      write_q <= bus.d_cmd_write;
      wdata_q <= bus.d_cmd_wdata;
      wstrb_q <= bus.d_cmd_wstrb;
      owner_q <= 1'b1;
    end else if (grant_i) begin
      addr_q  <= bus.i_cmd_addr;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      owner_q <= 1'b0;
    end
  end

  // Timeout forces an empty error; writes return no data.
  always_comb begin
    rsp_data_n = '0;
    rsp_err_n  = 1'b1;
    if (done) begin
      rsp_data_n = write_q ? '0 : bus.m_rsp_data;
      rsp_err_n  = bus.m_rsp_error;
    end
  end

  // Route the response to the owner as a 1-cycle pulse.
  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      i_vld_q  <= 1'b0;
      i_data_q <= '0;
      i_err_q  <= 1'b0;
      d_vld_q  <= 1'b0;
      d_data_q <= '0;
      d_err_q  <= 1'b0;
    end else begin
      i_vld_q <= (done | tmo) & ~owner_q;
      d_vld_q <= (done | tmo) & owner_q;
      if ((done | tmo) && owner_q) begin
        d_data_q <= rsp_data_n;
        d_err_q  <= rsp_err_n;
      end
      if ((done | tmo) && !owner_q) begin
        i_data_q <= rsp_data_n;
        i_err_q  <= rsp_err_n;
      end
    end
  end

  assign bus.i_cmd_ready = grant_i;
  assign bus.d_cmd_ready = grant_d;
  assign bus.m_cmd_valid = (state_q == CMD);
  assign bus.m_cmd_addr  = addr_q;
  assign bus.m_cmd_write = write_q;
  assign bus.m_cmd_wdata = wdata_q;
  assign bus.m_cmd_wstrb = wstrb_q;
  assign bus.i_rsp_valid = i_vld_q;
  assign bus.i_rsp_data  = i_data_q;
  assign bus.i_rsp_error = i_err_q;
  assign bus.d_rsp_valid = d_vld_q;
  assign bus.d_rsp_data  = d_data_q;
  assign bus.d_rsp_error = d_err_q;
  assign o_busy          = (state_q != IDLE);
  assign o_owner         = owner_q;
endmodule

// File: tb/tb_dand_bus_arbiter.sv
// Scoreboard bench for dand_bus_arbiter.
// Directed transactions; monitors pop expected cmds/rsps.
`timescale 1ns/1ps
module tb_dand_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = 8;
  localparam int TMO = 8;

  typedef struct packed {
    logic          dbus;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic owner;

  always #5 clk = ~clk;

  dand_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  dand_bus_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .io_axiClk(clk),
    .io_asyncResetn(rst_n),
    .bus(ifc.master),
    .o_busy(busy),
    .o_owner(owner)
  );

  rsp_t rsp_q[$];
  cmd_t cmd_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  int            sl_rdy_wait = 0;
  int            sl_rsp_wait = 0;
  bit            sl_respond = 1'b1;
  logic [DW-1:0] sl_data = '0;
  bit            sl_err = 1'b0;
  bit            sl_busy = 1'b0;

  function automatic void chk(string name,
                              logic [63:0] act,
                              logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  // Downstream slave model driven by the knobs above.
  initial begin
    cmd_t snap;
    cmd_t cur;
    ifc.m_cmd_ready = 1'b0;
    ifc.m_rsp_valid = 1'b0;
    ifc.m_rsp_data  = '0;
    ifc.m_rsp_error = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.m_cmd_valid === 1'b1) begin
        sl_busy = 1'b1;
        snap = '{ifc.m_cmd_addr, ifc.m_cmd_write,
                 ifc.m_cmd_wdata, ifc.m_cmd_wstrb};
        for (int k = 0; k < sl_rdy_wait; k++) begin
          @(negedge clk);
          cur = '{ifc.m_cmd_addr, ifc.m_cmd_write,
                  ifc.m_cmd_wdata, ifc.m_cmd_wstrb};
          chk("cmd_stable",
              {63'd0, ifc.m_cmd_valid && (cur == snap)}, 1);
        end
        ifc.m_cmd_ready = 1'b1;
        @(negedge clk);
        ifc.m_cmd_ready = 1'b0;
        if (sl_respond) begin
          repeat (sl_rsp_wait) @(negedge clk);
          ifc.m_rsp_valid = 1'b1;
          ifc.m_rsp_data  = sl_data;
          ifc.m_rsp_error = sl_err;
          @(negedge clk);
          ifc.m_rsp_valid = 1'b0;
          ifc.m_rsp_data  = '0;
          ifc.m_rsp_error = 1'b0;
        end
        sl_busy = 1'b0;
      end
    end
  end

  // Command monitor: every accepted downstream command.
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      #2;
      if (ifc.m_cmd_valid && ifc.m_cmd_ready) begin
        if (cmd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL cmd_stray: addr %0h", ifc.m_cmd_addr);
        end else begin
          e = cmd_q.pop_front();
          chk("cmd_addr", ifc.m_cmd_addr, e.addr);
          chk("cmd_write", ifc.m_cmd_write, e.wr);
          chk("cmd_wdata", ifc.m_cmd_wdata, e.wdata);
          chk("cmd_wstrb", ifc.m_cmd_wstrb, e.wstrb);
        end
      end
    end
  end

  // Response monitor: every rsp pulse toward a requester.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (ifc.i_rsp_valid || ifc.d_rsp_valid) begin
        chk("rsp_onehot",
            ifc.i_rsp_valid & ifc.d_rsp_valid, 0);
        if (rsp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_stray: i %0b d %0b",
                   ifc.i_rsp_valid, ifc.d_rsp_valid);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_owner", ifc.d_rsp_valid, e.dbus);
          chk("rsp_data", e.dbus ? ifc.d_rsp_data
                                 : ifc.i_rsp_data, e.data);
          chk("rsp_err", e.dbus ? ifc.d_rsp_error
                                : ifc.i_rsp_error, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || sl_busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", busy | sl_busy, 0);
  endtask

  task automatic txn(input bit d, input logic [AW-1:0] a,
                     input bit wr, input logic [DW-1:0] wd,
                     input logic [SW-1:0] ws,
                     input int rdyw, input int rspw,
                     input bit resp, input logic [DW-1:0] rd,
                     input bit re, input bit exp_tmo);
    cmd_t c;
    rsp_t r;
    wait_idle();
    sl_rdy_wait = rdyw;
    sl_rsp_wait = rspw;
    sl_respond  = resp;
    sl_data     = rd;
    sl_err      = re;
    c.addr  = a;
    c.wr    = d & wr;
    c.wdata = d ? wd : '0;
    c.wstrb = d ? ws : '0;
    r.dbus  = d;
    r.data  = (exp_tmo || (d && wr)) ? '0 : rd;
    r.err   = exp_tmo | re;
    @(negedge clk);
    if (d) begin
      ifc.d_cmd_valid = 1'b1;
      ifc.d_cmd_addr  = a;
      ifc.d_cmd_write = wr;
      ifc.d_cmd_wdata = wd;
      ifc.d_cmd_wstrb = ws;
    end else begin
      ifc.i_cmd_valid = 1'b1;
      ifc.i_cmd_addr  = a;
    end
    #1;
    chk("grant", d ? ifc.d_cmd_ready : ifc.i_cmd_ready, 1);
    chk("other_ready",
        d ? ifc.i_cmd_ready : ifc.d_cmd_ready, 0);
    cmd_q.push_back(c);
    rsp_q.push_back(r);
    @(negedge clk);
    ifc.i_cmd_valid = 1'b0;
    ifc.d_cmd_valid = 1'b0;
    #1;
    chk("m_cmd_latency", ifc.m_cmd_valid, 1);
  endtask

  initial begin
    bit   exp_d;
    int   cyc;
    cmd_t c;
    rsp_t r;
    ifc.i_cmd_valid = 1'b0;
    ifc.i_cmd_addr  = '0;
    ifc.d_cmd_valid = 1'b0;
    ifc.d_cmd_addr  = '0;
    ifc.d_cmd_write = 1'b0;
    ifc.d_cmd_wdata = '0;
    ifc.d_cmd_wstrb = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_m_valid", ifc.m_cmd_valid, 0);
    chk("rst_rsp", {ifc.i_rsp_valid, ifc.d_rsp_valid}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: single ibus read, response in the second RSP cycle.
    txn(0, 32'h8000_0000, 0, 64'hFFFF, 8'hFF,
        0, 1, 1, 64'h13, 0, 0);

    // 2: four ties.
    for (int k = 0; k < 4; k++) begin
      wait_idle();
      sl_rdy_wait = 0;
      sl_rsp_wait = 0;
      sl_respond  = 1'b1;
      sl_data     = 64'h100 + 64'(k);
      sl_err      = 1'b0;
      @(negedge clk);
      ifc.i_cmd_valid = 1'b1;
      ifc.i_cmd_addr  = 32'h2000_0000 + 32'(k * 4);
      ifc.d_cmd_valid = 1'b1;
      ifc.d_cmd_addr  = 32'h3000_0000 + 32'(k * 4);
      ifc.d_cmd_write = 1'b0;
      ifc.d_cmd_wdata = 64'h77;
      ifc.d_cmd_wstrb = 8'h0F;
      #1;
`ifdef DAND_ARB_ROUND_ROBIN_EN
      exp_d = (k % 2) == 1;
`else
      exp_d = 1'b1;
`endif
      chk("tie_i_ready", ifc.i_cmd_ready, !exp_d);
      chk("tie_d_ready", ifc.d_cmd_ready, exp_d);
      c.addr  = exp_d ? 32'h3000_0000 + 32'(k * 4)
                      : 32'h2000_0000 + 32'(k * 4);
      c.wr    = 1'b0;
      c.wdata = exp_d ? 64'h77 : '0;
      c.wstrb = exp_d ? 8'h0F : '0;
      r.dbus  = exp_d;
      r.data  = 64'h100 + 64'(k);
      r.err   = 1'b0;
      cmd_q.push_back(c);
      rsp_q.push_back(r);
      @(negedge clk);
      ifc.i_cmd_valid = 1'b0;
      ifc.d_cmd_valid = 1'b0;
      #1;
      chk("tie_owner", owner, exp_d);
    end

    // 3: dbus write held off by 5 not-ready cycles.
    txn(1, 32'h1000_0000, 1, 64'hA5, 8'h01,
        5, 0, 1, 64'hDEAD, 0, 0);

    // 4: slave answers only after the timeout.
    txn(0, 32'h4000_0000, 0, 64'h0, 8'h0,
        0, 10, 1, 64'hBAD, 0, 1);
    cyc = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
      cyc++;
    end
    chk("tmo_rsp_cycles", 64'(cyc), TMO);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("tmo_idle", busy, 0);
    chk("tmo_err_hold", ifc.i_rsp_error, 1);

    // 6: real response lands on the timeout cycle.
    txn(0, 32'h4000_0008, 0, 64'h0, 8'h0,
        0, TMO - 1, 1, 64'h66, 0, 0);

    // 5: reset while waiting in RSP.
    txn(1, 32'h5000_0000, 0, 64'h0, 8'h0,
        0, 0, 0, 64'h0, 0, 0);
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    void'(rsp_q.pop_back());
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_owner", owner, 0);
    chk("arst_m_valid", ifc.m_cmd_valid, 0);
    chk("arst_m_addr", ifc.m_cmd_addr, 0);
    chk("arst_rsp", {ifc.i_rsp_valid, ifc.d_rsp_valid,
                     ifc.i_rsp_error, ifc.d_rsp_error}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 32'h8000_0010, 0, 64'h0, 8'h0,
        0, 0, 1, 64'h5A5A, 1, 0);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(rsp_q.size() + cmd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
